tl_data_downsizer: RTL
======================

Name: tl_data_downsizer

Overview:
- TileLink adapter that narrows the data bus: wide host port, narrow device port. It is the counterpart of the data upsizer.
- A-channel wide beats are split into narrow beats. D-channel narrow beats are gathered back into wide beats.
- Covers TL-UL/TL-UH A and D channels only. No B/C/E channels.
- Source width is unchanged; no sideband information is carried in source.
- Sits between a wide-bus host (core/cache) and a narrow-bus device or interconnect segment.

Parameters:
- HostDataWidth, 64, host data width in bits (power of two).
- DeviceDataWidth, 32, device data width in bits (power of two, < HostDataWidth).
- AddrWidth, 56, address width.
- SourceWidth, 1, source ID width (same on both sides).
- SinkWidth, 1, sink ID width.
- MaxSize, 6, log2 of the largest transfer in bytes.
- Derived: Ratio = HostDataWidth/DeviceDataWidth; HNB = log2(HostDataWidth/8); DNB = log2(DeviceDataWidth/8).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- host_a_valid / host_a_ready  input / output  1 / 1  host A handshake
- host_a_opcode, host_a_param, host_a_size  input  3 each  A fields
- host_a_source  input  SourceWidth;  host_a_address  input  AddrWidth
- host_a_mask  input  HostDataWidth/8;  host_a_data  input  HostDataWidth;  host_a_corrupt  input  1
- host_d_valid / host_d_ready  output / input  1 / 1  host D handshake
- host_d_opcode, host_d_param, host_d_size  output  3 each;  host_d_source  output  SourceWidth;  host_d_sink  output  SinkWidth
- host_d_denied, host_d_corrupt  output  1 each;  host_d_data  output  HostDataWidth
- device_a_* outputs mirroring the host_a_* fields; mask DeviceDataWidth/8, data DeviceDataWidth; device_a_ready input
- device_d_* inputs mirroring the host_d_* fields; data DeviceDataWidth; device_d_ready output

Behaviour:
- **Reset.** Reset is asynchronous, active-high. It clears a_cnt, d_cnt, the gather registers, and the sticky denied/corrupt flags. Any partial split or gather in progress is discarded. device_a_valid and host_d_valid are combinational and read 0 whenever their source valid is 0.
- **A beat count.** n_a = 1 if the opcode carries no data (Get/Intent) or size <= DNB. Otherwise n_a = 2^(min(size,HNB)-DNB).
- **A lane selection.** a_cnt (log2 Ratio bits) counts sub-beats. lane = address[HNB-1:DNB] + a_cnt, wrapped to log2(Ratio) bits.
- **A channel outputs.**
  - device_a_valid = host_a_valid.
  - device_a_data and device_a_mask = the selected lane.
  - All other fields pass through unchanged, including size and address.
  - host_a_ready = device_a_ready only when a_cnt == n_a-1; otherwise 0.
  - On each device A handshake, a_cnt increments. It wraps to 0 on the last sub-beat.
- **A channel notes.**
  - Get produces one device beat with the original size.
  - Latency is zero: the first sub-beat appears in the same cycle as host_a_valid.
- **D beat count.** n_d = 1 if the opcode is AccessAck (no data) or size <= DNB. Otherwise n_d = 2^(min(size,HNB)-DNB).
- **D gather.** d_cnt counts narrow beats in the current wide beat.
  - Beats with d_cnt < n_d-1 are accepted unconditionally (device_d_ready = 1) and stored in gather lane d_cnt.
  - On beat n_d-1: host_d_valid = device_d_valid, and device_d_ready = host_d_ready.
  - host_d_data = the n_d-lane group {incoming, stored lanes}, replicated across host width. With n_d = Ratio there is no replication.
  - Zero added latency on the completing beat.
- **D fields.**
  - denied/corrupt are the OR of the sticky flags and the incoming beat.
  - Flags and d_cnt clear after the host handshake.
  - Other fields come from the completing beat.
  - Non-data responses pass through 1:1.
- **Backpressure.** A stalled completing beat holds the gather registers and d_cnt stable.
- **Independence.** The A and D paths are independent; simultaneous activity on both is legal.
- **Ordering.** Per-source ordering is unchanged. No outstanding-transaction tracking is required.

Test Plan:
- **Split PutFull.** HostDataWidth=64, DeviceDataWidth=32, always-ready device. PutFullData size 3 @0x100, data 0x1122334455667788, mask 0xFF -> device beats (0x55667788, mask 0xF) then (0x11223344, mask 0xF), both size 3 @0x100. host_a_ready is high only on the second cycle.
- **Upper-lane PutPartial.** PutPartialData size 2 @0x104, data 0xAABBCCDD_00000000, mask 0xF0 -> one device beat: data 0xAABBCCDD, mask 0xF. host_a_ready is high in the same cycle.
- **Small Get.** Get size 2 @0x104, device returns AccessAckData 0xDEADBEEF -> one host D beat, data 0xDEADBEEFDEADBEEF, size 2.
- **Burst Get.** Get size 6 @0x40 -> exactly one device A beat, size 6. The device returns 16 narrow beats 0..15 -> the host sees 8 beats; beat k = {2k+1, 2k}.
- **Backpressure.** device_a_ready=0 during sub-beat 1 holds a_cnt=1 and host_a_ready=0. host_d_ready=0 on a completing beat forces device_d_ready=0 and keeps host_d_data stable for 3 cycles.
- **Corrupt and reset.** corrupt=1 on narrow beat 0 only -> host_d_corrupt=1 on the wide beat, and the next wide beat shows 0. Asserting rst_i after one narrow beat -> the next response gathers from lane 0.

Source files
------------

// File: rtl/tl_data_downsizer_if.sv
// TileLink UL/UH A+D channel bundle. The master drives A and receives D;
// the slave receives A and drives D.
interface tl_data_downsizer_if #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned SourceWidth = 1,
  parameter int unsigned SinkWidth   = 1
);
  logic                     a_valid;
  logic                     a_ready;
  logic [2:0]               a_opcode;
  logic [2:0]               a_param;
  logic [2:0]               a_size;
  logic [SourceWidth-1:0]   a_source;
  logic [AddrWidth-1:0]     a_address;
  logic [DataWidth/8-1:0]   a_mask;
  logic [DataWidth-1:0]     a_data;
  logic                     a_corrupt;

  logic                     d_valid;
  logic                     d_ready;
  logic [2:0]               d_opcode;
  logic [2:0]               d_param;
  logic [2:0]               d_size;
  logic [SourceWidth-1:0]   d_source;
  logic [SinkWidth-1:0]     d_sink;
  logic                     d_denied;
  logic                     d_corrupt;
  logic [DataWidth-1:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_data_downsizer.sv
// TileLink data-bus narrower: splits wide A beats into narrow device beats and
// gathers narrow D beats back into wide host beats, both with zero added latency.
module tl_data_downsizer #(
  parameter int unsigned HostDataWidth   = 64,
  parameter int unsigned DeviceDataWidth = 32,
  parameter int unsigned AddrWidth       = 56,
  parameter int unsigned SourceWidth     = 1,
  parameter int unsigned SinkWidth       = 1,
  parameter int unsigned MaxSize         = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  tl_data_downsizer_if.slave  host,
  tl_data_downsizer_if.master device
);

  localparam int unsigned Ratio   = HostDataWidth / DeviceDataWidth;
  localparam int unsigned RB      = $clog2(Ratio);
  localparam int unsigned HNB     = $clog2(HostDataWidth / 8);
  localparam int unsigned DNB     = $clog2(DeviceDataWidth / 8);
  localparam int unsigned DMW     = DeviceDataWidth / 8;
  localparam int unsigned SizeCap = (MaxSize < HNB) ? MaxSize : HNB;

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  // Index of the last narrow beat of one wide beat (n - 1).
  function automatic logic [RB-1:0] beat_last(input logic [2:0] size, input logic has_data);
    int unsigned sz;
    logic [RB:0] n;
    sz = (int'(size) > int'(SizeCap)) ? SizeCap : int'(size);
    if (!has_data || sz <= DNB) return '0;
    n = (RB+1)'(1) << (sz - DNB);
    return RB'(n - 1'b1);
  endfunction

  // ---------------------------------------------------------------- A channel
  logic [RB-1:0] a_cnt_q, a_cnt_d;
  logic [RB-1:0] a_last;
  logic [RB-1:0] a_lane;

  // NOTE: every combinational output is given a default first so no path can infer a latch.
  always_comb begin
    a_last  = beat_last(host.a_size, host.a_opcode < OpGet);
    a_lane  = host.a_address[HNB-1:DNB] + a_cnt_q;
    a_cnt_d = a_cnt_q;
    if (host.a_valid && device.a_ready) begin
      a_cnt_d = (a_cnt_q == a_last) ? '0 : a_cnt_q + 1'b1;
    end
  end

  assign device.a_valid   = host.a_valid;
  assign device.a_opcode  = host.a_opcode;
  assign device.a_param   = host.a_param;
  assign device.a_size    = host.a_size;
  assign device.a_source  = host.a_source;
  assign device.a_address = host.a_address;
  assign device.a_corrupt = host.a_corrupt;
  assign device.a_data    = host.a_data[a_lane*DeviceDataWidth +: DeviceDataWidth];
  assign device.a_mask    = host.a_mask[a_lane*DMW +: DMW];
  assign host.a_ready     = (a_cnt_q == a_last) && device.a_ready;

  // ---------------------------------------------------------------- D channel
  logic [RB-1:0]              d_cnt_q, d_cnt_d;
  logic [RB-1:0]              d_last;
  logic                       d_completing;
  logic [DeviceDataWidth-1:0] gather_q [Ratio];
  logic [DeviceDataWidth-1:0] gather_d [Ratio];
  logic                       denied_q, denied_d;
  logic                       corrupt_q, corrupt_d;
  logic [HostDataWidth-1:0]   d_data_wide;
  logic [RB-1:0]              grp_lane;

  always_comb begin
    d_last       = beat_last(device.d_size, device.d_opcode == OpAccessAckData);
    d_completing = (d_cnt_q >= d_last);

    // An n_d-lane group (stored lanes plus the incoming beat) repeated across the host bus.
    d_data_wide = '0;
    grp_lane    = '0;
    for (int i = 0; i < Ratio; i++) begin
      grp_lane = RB'(i) & d_last;
      d_data_wide[i*DeviceDataWidth +: DeviceDataWidth] =
        (grp_lane == d_last) ? device.d_data : gather_q[grp_lane];
    end

    d_cnt_d   = d_cnt_q;
    gather_d  = gather_q;
    denied_d  = denied_q;
    corrupt_d = corrupt_q;
    if (device.d_valid) begin
      if (!d_completing) begin
        gather_d[d_cnt_q] = device.d_data;
        d_cnt_d           = d_cnt_q + 1'b1;
        denied_d          = denied_q | device.d_denied;
        corrupt_d         = corrupt_q | device.d_corrupt;
      end else if (host.d_ready) begin
        d_cnt_d   = '0;
        denied_d  = 1'b0;
        corrupt_d = 1'b0;
      end
    end
  end

  assign device.d_ready  = d_completing ? host.d_ready : 1'b1;
  assign host.d_valid    = device.d_valid && d_completing;
  assign host.d_opcode   = device.d_opcode;
  assign host.d_param    = device.d_param;
  assign host.d_size     = device.d_size;
  assign host.d_source   = device.d_source;
  assign host.d_sink     = device.d_sink;
  assign host.d_denied   = denied_q | device.d_denied;
  assign host.d_corrupt  = corrupt_q | device.d_corrupt;
  assign host.d_data     = d_data_wide;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: the gather lanes are reset too, so a discarded partial gather can never leak into a later response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_cnt_q   <= '0;
      d_cnt_q   <= '0;
      denied_q  <= 1'b0;
      corrupt_q <= 1'b0;
      for (int i = 0; i < Ratio; i++) gather_q[i] <= '0;
    end else begin
      a_cnt_q   <= a_cnt_d;
      d_cnt_q   <= d_cnt_d;
      denied_q  <= denied_d;
      corrupt_q <= corrupt_d;
      gather_q  <= gather_d;
    end
  end

endmodule
